// File: rtl/ts_pkg.sv
// Shared constants and FSM encoding for the pseudo-TS receive path.
// Pure declarations: no latency and no backpressure apply.
// Imported by the demux top and its lane router.
package ts_pkg;

    localparam int          TS_PKT_LEN   = 188;
    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
    localparam int          NUM_CH       = 4;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } state_t;

endpackage

// File: rtl/ts_lane_router.sv
// Registered 1-to-NUM_CH byte steering; idle lanes are zero-filled every cycle.
// Latency: 1 cycle from an accepted byte to its lane.
// Backpressure: none, one byte per cycle is always taken.
module ts_lane_router
    import ts_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  byte_vld,
    input  logic [1:0]            lane,
    input  logic [7:0]            byte_dat,
    input  logic                  byte_sync,
    output logic [8*NUM_CH-1:0]   lane_dat,
    output logic [NUM_CH-1:0]     lane_vld,
    output logic [NUM_CH-1:0]     lane_sync
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lane_dat  <= '0;
            lane_vld  <= '0;
            lane_sync <= '0;
        end else begin
            lane_dat  <= '0;
            lane_vld  <= '0;
            lane_sync <= '0;
            if (byte_vld) begin
                lane_dat[8*lane +: 8] <= byte_dat;
                lane_vld[lane]        <= 1'b1;
                lane_sync[lane]       <= byte_sync;
            end
        end
    end

endmodule

// File: rtl/pseudo_ts_demux.sv
// Pseudo-TS demux: strips the header, routes each TS packet to lane idx, counts framing errors.
// Latency: 1 cycle from accepted byte to lane output. Optional macro PSEUDO_TS_DEMUX_PKT_CNT_EN.
// Backpressure: none; bytes with D_VALID_IN=0 are ignored entirely.
module pseudo_ts_demux
    import ts_pkg::*;
#(
    parameter int HDR_LEN = 4,
    parameter int IDX_POS = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  DATA_IN,
    input  logic        D_VALID_IN,
    input  logic        P_SYNC_IN,
    output logic [31:0] DATA_OUT,
    output logic [3:0]  D_VALID_OUT,
    output logic [3:0]  P_SYNC_OUT,
    output logic        ERR_PULSE,
    output logic [15:0] ERR_CNT,
    output logic [63:0] PKT_CNT_BUS
);

    localparam logic [7:0] HDR_LAST = 8'(HDR_LEN - 1);
    localparam logic [7:0] PAY_LAST = 8'(TS_PKT_LEN - 1);
    localparam logic [7:0] IDX_AT   = 8'(IDX_POS);

    state_t     state, state_n;
    logic [7:0] byte_cnt, cnt_n;
    logic [7:0] idx, idx_n;
    logic       emit, emit_sync, err;

    always_comb begin
        state_n   = state;
        cnt_n     = byte_cnt;
        idx_n     = idx;
        emit      = 1'b0;
        emit_sync = 1'b0;
        err       = 1'b0;
        if (D_VALID_IN) begin
            if (P_SYNC_IN) begin
                // A marker outside HUNT means the previous packet was cut short.
                err = (state != HUNT);
                if (IDX_POS == 0) idx_n = DATA_IN;
                if (HDR_LEN == 1) begin
                    state_n = PAYLOAD;
                    cnt_n   = 8'd0;
                end else begin
                    state_n = HEADER;
                    cnt_n   = 8'd1;
                end
            end else begin
                case (state)
                    HUNT: ;
                    HEADER: begin
                        if (byte_cnt == IDX_AT) idx_n = DATA_IN;
                        if (byte_cnt == HDR_LAST) begin
                            state_n = PAYLOAD;
                            cnt_n   = 8'd0;
                        end else begin
                            cnt_n = byte_cnt + 8'd1;
                        end
                    end
                    PAYLOAD: begin
                        if (byte_cnt == 8'd0 && (DATA_IN != TS_SYNC_BYTE || idx > 8'd3)) begin
                            err     = 1'b1;
                            state_n = DROP;
                            cnt_n   = 8'd1;
                        end else begin
                            emit      = 1'b1;
                            emit_sync = (byte_cnt == 8'd0);
                            if (byte_cnt == PAY_LAST) begin
                                state_n = HUNT;
                                cnt_n   = 8'd0;
                            end else begin
                                cnt_n = byte_cnt + 8'd1;
                            end
                        end
                    end
                    DROP: begin
                        if (byte_cnt == PAY_LAST) begin
                            state_n = HUNT;
                            cnt_n   = 8'd0;
                        end else begin
                            cnt_n = byte_cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= HUNT;
            byte_cnt  <= 8'd0;
            idx       <= 8'd0;
            ERR_PULSE <= 1'b0;
            ERR_CNT   <= 16'd0;
        end else begin
            state     <= state_n;
            byte_cnt  <= cnt_n;
            idx       <= idx_n;
            ERR_PULSE <= err;
            if (err && ERR_CNT != 16'hFFFF) ERR_CNT <= ERR_CNT + 16'd1;
        end
    end

    ts_lane_router u_router (
        .CLK       (CLK),
        .RST       (RST),
        .byte_vld  (emit),
        .lane      (idx[1:0]),
        .byte_dat  (DATA_IN),
        .byte_sync (emit_sync),
        .lane_dat  (DATA_OUT),
        .lane_vld  (D_VALID_OUT),
        .lane_sync (P_SYNC_OUT)
    );

`ifdef PSEUDO_TS_DEMUX_PKT_CNT_EN
    logic pkt_done;
    assign pkt_done = emit && (byte_cnt == PAY_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PKT_CNT_BUS <= '0;
        end else if (pkt_done) begin
            PKT_CNT_BUS[16*idx[1:0] +: 16] <= PKT_CNT_BUS[16*idx[1:0] +: 16] + 16'd1;
        end
    end
`else
    assign PKT_CNT_BUS = '0;
`endif

endmodule

// File: tb/tb_pseudo_ts_demux.sv
// Bench for pseudo_ts_demux: table of packets driven through a scoreboard,
// plus hand-written reset-mid-packet sequence.
module tb_pseudo_ts_demux;

    localparam int HDR_LEN = 4;
    localparam int IDX_POS = 0;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  DATA_IN;
    logic        D_VALID_IN;
    logic        P_SYNC_IN;
    logic [31:0] DATA_OUT;
    logic [3:0]  D_VALID_OUT;
    logic [3:0]  P_SYNC_OUT;
    logic        ERR_PULSE;
    logic [15:0] ERR_CNT;
    logic [63:0] PKT_CNT_BUS;

    pseudo_ts_demux #(.HDR_LEN(HDR_LEN), .IDX_POS(IDX_POS)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .DATA_IN     (DATA_IN),
        .D_VALID_IN  (D_VALID_IN),
        .P_SYNC_IN   (P_SYNC_IN),
        .DATA_OUT    (DATA_OUT),
        .D_VALID_OUT (D_VALID_OUT),
        .P_SYNC_OUT  (P_SYNC_OUT),
        .ERR_PULSE   (ERR_PULSE),
        .ERR_CNT     (ERR_CNT),
        .PKT_CNT_BUS (PKT_CNT_BUS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] lane;
        logic [7:0] dat;
        logic       sync;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] idx;
        logic [7:0] b0;
        int         len;
        int         gap;
        int         exp_err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   err_pulses = 0;
    logic [15:0] pkt_model [4];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        exp_t e;
        if (ERR_PULSE) err_pulses++;
        if (D_VALID_OUT != 4'd0) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {28'd0, D_VALID_OUT}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("lane_vld",  {60'd0, D_VALID_OUT}, {60'd0, 4'b0001 << e.lane});
                check("lane_dat",  {32'd0, DATA_OUT}, {32'd0, 32'(e.dat) << (8 * e.lane)});
                check("lane_sync", {60'd0, P_SYNC_OUT}, {60'd0, 4'(e.sync) << e.lane});
                check("latency",   64'(cyc), 64'(e.cyc + 1));
            end
        end else begin
            check("idle_zero", {28'd0, DATA_OUT, P_SYNC_OUT}, 64'd0);
        end
    end

    task automatic drv(input logic [7:0] d, input logic s);
        DATA_IN    = d;
        D_VALID_IN = 1'b1;
        P_SYNC_IN  = s;
        @(posedge CLK);
        #1;
        D_VALID_IN = 1'b0;
        P_SYNC_IN  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_pkt(input logic [7:0] idx, input logic [7:0] b0, input int len, input int gap);
        logic       good;
        logic [7:0] d;
        exp_t       e;
        good = (b0 == 8'h47) && (idx <= 8'd3);
        for (int h = 0; h < HDR_LEN; h++) begin
            drv((h == IDX_POS) ? idx : 8'h00, h == 0);
            idle(gap);
        end
        for (int j = 0; j < len; j++) begin
            d = (j == 0) ? b0 : j[7:0];
            if (good) begin
                e.lane = idx[1:0];
                e.dat  = d;
                e.sync = (j == 0);
                e.cyc  = cyc;
                sb.push_back(e);
            end
            drv(d, 1'b0);
            idle(gap);
        end
        if (good && len == 188) pkt_model[idx[1:0]]++;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge CLK);
        #1;
        check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_pkt_cnt();
`ifdef PSEUDO_TS_DEMUX_PKT_CNT_EN
        check("pkt_cnt_bus", PKT_CNT_BUS,
              {pkt_model[3], pkt_model[2], pkt_model[1], pkt_model[0]});
`else
        check("pkt_cnt_bus_tied", PKT_CNT_BUS, 64'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // idx, payload byte 0, payload bytes sent, invalid gap, ERR_CNT after
        vecs[0] = '{8'd0, 8'h47, 188, 0, 0};  // basic lane 0
        vecs[1] = '{8'd3, 8'h47, 188, 0, 0};  // back-to-back 3,1,2
        vecs[2] = '{8'd1, 8'h47, 188, 0, 0};
        vecs[3] = '{8'd2, 8'h47, 188, 0, 0};
        vecs[4] = '{8'd2, 8'h46, 188, 0, 1};  // bad sync byte
        vecs[5] = '{8'd0, 8'h47, 188, 0, 1};  // recovers
        vecs[6] = '{8'd5, 8'h47, 188, 0, 2};  // idx out of range
        vecs[7] = '{8'd1, 8'h47, 100, 0, 2};  // truncated at payload byte 100
        vecs[8] = '{8'd2, 8'h47, 188, 0, 3};  // starts on the truncating byte
        vecs[9] = '{8'd3, 8'h47, 188, 2, 3};  // valid 1-of-3 cycles
        for (int l = 0; l < 4; l++) pkt_model[l] = 16'd0;

        RST        = 1'b1;
        DATA_IN    = 8'h00;
        D_VALID_IN = 1'b0;
        P_SYNC_IN  = 1'b0;
        idle(3);
        check("rst_vld",  {60'd0, D_VALID_OUT}, 64'd0);
        check("rst_dat",  {32'd0, DATA_OUT}, 64'd0);
        check("rst_sync", {60'd0, P_SYNC_OUT}, 64'd0);
        check("rst_errp", {63'd0, ERR_PULSE}, 64'd0);
        check("rst_errc", {48'd0, ERR_CNT}, 64'd0);
        check("rst_pkt",  PKT_CNT_BUS, 64'd0);
        RST = 1'b0;
        idle(2);

        for (int i = 0; i < 10; i++) begin
            send_pkt(vecs[i].idx, vecs[i].b0, vecs[i].len, vecs[i].gap);
            check("err_cnt",    {48'd0, ERR_CNT}, 64'(vecs[i].exp_err));
            check("err_pulses", 64'(err_pulses), 64'(vecs[i].exp_err));
        end
        drain("drain_table");
        check_pkt_cnt();

        // Reset in the middle of a lane-1 payload.
        send_pkt(8'd1, 8'h47, 50, 0);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check("async_rst_vld",  {60'd0, D_VALID_OUT}, 64'd0);
        check("async_rst_dat",  {32'd0, DATA_OUT}, 64'd0);
        check("async_rst_errc", {48'd0, ERR_CNT}, 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        err_pulses = 0;
        for (int l = 0; l < 4; l++) pkt_model[l] = 16'd0;
        check("rst_sb_empty", 64'(sb.size()), 64'd0);

        // Unmarked bytes after reset must be ignored if the FSM is hunting.
        for (int k = 0; k < 5; k++) drv(8'h47, 1'b0);
        send_pkt(8'd0, 8'h47, 188, 0);
        check("post_rst_errc",    {48'd0, ERR_CNT}, 64'd0);
        check("post_rst_pulses",  64'(err_pulses), 64'd0);
        drain("drain_post_rst");
        check_pkt_cnt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
